ram_memory_piped: RTL and testbench

RAM_MEMORY_PIPED -- requirements
Module: ram_memory_piped

---
 rtl/rcpu_mem_pkg.sv | 15 +
 rtl/ram_read_pipe.sv | 40 ++++
 rtl/ram_memory_piped.sv | 104 ++++++++++
 tb/tb_ram_memory_piped.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_mem_pkg.sv
// Shared defaults and the read-pipeline stage record for the piped RAM.
// The stage struct here is sized for the default word width; wider instances define their own.
package rcpu_mem_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DEPTH        = 4096;
  localparam int MAX_READ_LATENCY = 4;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/ram_read_pipe.sv
// Delay line for read results: STAGES registered (valid, data) stages.
// Each stage's data only advances with a valid result, so the last stage holds between results.
module ram_read_pipe
  import rcpu_mem_pkg::*;
#(
  parameter int  STAGES  = 1,
  parameter type stage_t = rd_stage_t
) (
  input  logic   clk,
  input  logic   resetq,
  input  stage_t in_stage,
  output stage_t out_stage
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t prev;
    stage_t stage_d;
    stage_t stage_q;

    if (gi == 0) begin : g_first
      assign prev = in_stage;
    end else begin : g_next
      assign prev = g_stage[gi-1].stage_q;
    end

    always_comb begin
      stage_d       = stage_q;
      stage_d.valid = prev.valid;
      if (prev.valid) stage_d.data = prev.data;
    end

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) stage_q <= '0;
      else         stage_q <= stage_d;
    end
  end

  assign out_stage = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/ram_memory_piped.sv
// Single-port-write / single-port-read RAM with pipelined reads, address wrap and sticky OOB flag.
// Define RAM_MEMORY_BYPASS_EN for write-first same-address collisions; default is read-first.
module ram_memory_piped
  import rcpu_mem_pkg::*;
#(
  parameter int    DATA_W       = DEF_DATA_W,
  parameter int    ADDR_W       = DEF_ADDR_W,
  parameter int    DEPTH        = DEF_DEPTH,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              addr_oob
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              wr_oob;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_word;
  stage_t            rd_stage_d;
  stage_t            rd_stage_q;
  stage_t            out_stage;
  logic              addr_oob_d;
  logic              addr_oob_q;

  // One extra bit of headroom keeps the compare and modulo valid when DEPTH == 2**ADDR_W.
  always_comb begin
    wr_idx = IDX_W'({1'b0, write_addr} % DEPTH_EXT);
    rd_idx = IDX_W'({1'b0, read_addr} % DEPTH_EXT);
    wr_oob = ({1'b0, write_addr} >= DEPTH_EXT);
    rd_oob = ({1'b0, read_addr} >= DEPTH_EXT);
  end

`ifdef RAM_MEMORY_BYPASS_EN
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (write_enable && (wr_idx == rd_idx)) rd_word = write_data;
  end
`else
  always_comb begin
    rd_word = mem_q[rd_idx];
  end
`endif

  // Array is never reset; writes are simply dropped while reset is held.
  always @(posedge clk) begin
    if (resetq && write_enable) mem_q[wr_idx] <= write_data;
  end

  always_comb begin
    rd_stage_d       = rd_stage_q;
    rd_stage_d.valid = read_enable;
    if (read_enable) rd_stage_d.data = rd_word;
    addr_oob_d = addr_oob_q | (write_enable & wr_oob) | (read_enable & rd_oob);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_stage_q <= '0;
      addr_oob_q <= 1'b0;
    end else begin
      rd_stage_q <= rd_stage_d;
      addr_oob_q <= addr_oob_d;
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    ram_read_pipe #(
      .STAGES  (READ_LATENCY - 1),
      .stage_t (stage_t)
    ) u_read_pipe (
      .clk       (clk),
      .resetq    (resetq),
      .in_stage  (rd_stage_q),
      .out_stage (out_stage)
    );
  end else begin : g_direct
    assign out_stage = rd_stage_q;
  end

  assign read_data  = out_stage.data;
  assign read_valid = out_stage.valid;
  assign addr_oob   = addr_oob_q;

endmodule

// File: tb/tb_ram_memory_piped.sv
// Four instances (READ_LATENCY 1..4) share stimulus; per-instance scoreboards check every read result.
// Build with RAM_MEMORY_BYPASS_EN defined to check the write-first collision rule instead of read-first.
module tb_ram_memory_piped;

  localparam int DEPTH = 4096;
  localparam int NINST = 4;
`ifdef RAM_MEMORY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        write_enable = 1'b0;
  logic [15:0] write_addr = '0;
  logic [15:0] write_data = '0;
  logic        read_enable = 1'b0;
  logic [15:0] read_addr = '0;
  logic [15:0] rd_w  [NINST];
  logic        rv_w  [NINST];
  logic        oob_w [NINST];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q [NINST][$];
  logic [15:0] model_mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
    ram_memory_piped #(.READ_LATENCY(gi + 1)) u_dut (
      .clk          (clk),
      .resetq       (resetq),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_enable  (read_enable),
      .read_addr    (read_addr),
      .read_data    (rd_w[gi]),
      .read_valid   (rv_w[gi]),
      .addr_oob     (oob_w[gi])
    );

    logic [15:0] last = '0;
    exp_t        e;

    always @(negedge clk) begin
      if (!resetq) begin
        last = '0;
      end else if (rv_w[gi]) begin
        checks++;
        if (exp_q[gi].size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid L=%0d cyc=%0d data=%h required=no pulse", gi + 1, cyc, rd_w[gi]);
        end else begin
          e = exp_q[gi].pop_front();
          if (rd_w[gi] !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL read_result L=%0d data=%h cyc=%0d required data=%h cyc=%0d",
                     gi + 1, rd_w[gi], cyc, e.data, e.due);
          end
        end
        last = rd_w[gi];
      end else begin
        checks++;
        if (rd_w[gi] !== last) begin
          failures++;
          $display("FAIL hold L=%0d cyc=%0d data=%h required=%h", gi + 1, cyc, rd_w[gi], last);
        end
        if (exp_q[gi].size() != 0 && exp_q[gi][0].due <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_valid L=%0d cyc=%0d read_valid=0 required=1", gi + 1, cyc);
          void'(exp_q[gi].pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue one cycle of requests; called #1 after a rising edge, samples at the next edge.
  task automatic step(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                      input logic re, input logic [15:0] ra);
    int   n;
    exp_t e;
    n = cyc + 1;
    write_enable = we; write_addr = wa; write_data = wd;
    read_enable  = re; read_addr  = ra;
    if (re) begin
      e.data = model_mem[int'(ra) % DEPTH];
      if (BYPASS && we && (int'(wa) % DEPTH) == (int'(ra) % DEPTH)) e.data = wd;
      for (int k = 0; k < NINST; k++) begin
        e.due = n + k;
        exp_q[k].push_back(e);
      end
    end
    if (we) model_mem[int'(wa) % DEPTH] = wd;
    @(posedge clk); #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic check_oob(input string name, input logic req);
    for (int k = 0; k < NINST; k++) chk($sformatf("%s_L%0d", name, k + 1), 32'(oob_w[k]), 32'(req));
  endtask

  task automatic check_drained(input string name);
    for (int k = 0; k < NINST; k++) chk($sformatf("%s_L%0d", name, k + 1), exp_q[k].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NINST; k++) begin
      chk($sformatf("reset_data_L%0d", k + 1), 32'(rd_w[k]), 0);
      chk($sformatf("reset_valid_L%0d", k + 1), 32'(rv_w[k]), 0);
      chk($sformatf("reset_oob_L%0d", k + 1), 32'(oob_w[k]), 0);
    end
    resetq = 1'b1;

    // Fill the locations used below so every read has a known answer.
    for (int a = 0; a < 16; a++) step(1'b1, 16'(a), 16'($urandom), 1'b0, 16'h0);

    // Back-to-back reads of 0..7.
    for (int a = 0; a < 8; a++) step(1'b0, 16'h0, 16'h0, 1'b1, 16'(a));
    idle(5);

    // Latency sweep on address 5.
    step(1'b1, 16'd5, 16'hBEEF, 1'b0, 16'h0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'd5);
    idle(5);

    // Same-edge collision at address 9, then a plain follow-up read.
    step(1'b1, 16'd9, 16'h1111, 1'b0, 16'h0);
    step(1'b1, 16'd9, 16'h2222, 1'b1, 16'd9);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'd9);
    idle(5);
    check_oob("oob_clear", 1'b0);

    // Out-of-range write wraps onto address 4 and sets the sticky flag.
    step(1'b1, 16'd4100, 16'hAAAA, 1'b0, 16'h0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'd4);
    idle(5);
    check_oob("oob_set", 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] wa;
      logic [15:0] ra;
      wa = 16'($urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 4096 : 0));
      ra = 16'($urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 4096 : 0));
      step(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 2) != 0), ra);
    end
    idle(6);
    check_drained("drain_random");
    check_oob("oob_sticky", 1'b1);

    // Reset between edges while a read is still inside the deeper pipelines.
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'd5);
    @(posedge clk);
    @(negedge clk); #1;
    resetq = 1'b0;
    #1;
    for (int k = 0; k < NINST; k++) begin
      chk($sformatf("midreset_data_L%0d", k + 1), 32'(rd_w[k]), 0);
      chk($sformatf("midreset_valid_L%0d", k + 1), 32'(rv_w[k]), 0);
      chk($sformatf("midreset_oob_L%0d", k + 1), 32'(oob_w[k]), 0);
      exp_q[k].delete();
    end
    write_enable = 1'b1; write_addr = 16'd5; write_data = ~model_mem[5];
    @(posedge clk); #1;
    write_enable = 1'b0;
    @(posedge clk); #1;
    resetq = 1'b1;
    idle(6);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'd5);
    idle(6);
    check_drained("drain_final");
    check_oob("oob_after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
